// File: rtl/whirlpool_round_unit.sv
// Whirlpool round unit: rho[k](A) = sigma[k](theta(pi(gamma(A)))).
// The pi column shift is a byte mux in front of PAR process_row instances
// (gamma + theta); each result is XORed with its key row and written into
// state_out. A full round takes 8/PAR cycles, then the result is held until taken.

// One Whirlpool row: S-box on every byte (gamma), then multiply by the
// circulant MDS matrix cir(1,1,4,1,8,5,2,9) over GF(2^8) mod 0x11D (theta).
module process_row (
    input  logic [63:0] row_in,
    output logic [63:0] row_out
);

    // 4-bit mini-box E
    function automatic logic [3:0] e_box(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h1;  4'h1: y = 4'hB;  4'h2: y = 4'h9;  4'h3: y = 4'hC;
            4'h4: y = 4'hD;  4'h5: y = 4'h6;  4'h6: y = 4'hF;  4'h7: y = 4'h3;
            4'h8: y = 4'hE;  4'h9: y = 4'h8;  4'hA: y = 4'h7;  4'hB: y = 4'h4;
            4'hC: y = 4'hA;  4'hD: y = 4'h2;  4'hE: y = 4'h5;  4'hF: y = 4'h0;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    // 4-bit mini-box E^-1
    function automatic logic [3:0] ei_box(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hF;  4'h1: y = 4'h0;  4'h2: y = 4'hD;  4'h3: y = 4'h7;
            4'h4: y = 4'hB;  4'h5: y = 4'hE;  4'h6: y = 4'h5;  4'h7: y = 4'hA;
            4'h8: y = 4'h9;  4'h9: y = 4'h2;  4'hA: y = 4'hC;  4'hB: y = 4'h1;
            4'hC: y = 4'h3;  4'hD: y = 4'h4;  4'hE: y = 4'h8;  4'hF: y = 4'h6;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    // 4-bit mini-box R
    function automatic logic [3:0] r_box(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h7;  4'h1: y = 4'hC;  4'h2: y = 4'hB;  4'h3: y = 4'hD;
            4'h4: y = 4'hE;  4'h5: y = 4'h4;  4'h6: y = 4'h9;  4'h7: y = 4'hF;
            4'h8: y = 4'h6;  4'h9: y = 4'h3;  4'hA: y = 4'h8;  4'hB: y = 4'hA;
            4'hC: y = 4'h2;  4'hD: y = 4'h5;  4'hE: y = 4'h1;  4'hF: y = 4'h0;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    // Whirlpool S-box built from the E / E^-1 / R mini-boxes
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] t;
        a = e_box(x[7:4]);
        b = ei_box(x[3:0]);
        t = r_box(a ^ b);
        return {e_box(a ^ t), ei_box(b ^ t)};
    endfunction

    // Multiply by x in GF(2^8) with reduction polynomial 0x11D
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    endfunction

    // Multiply by a small (4-bit) constant via shift-and-add
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int b = 0; b < 4; b++) begin
            if (c[b]) begin
                acc = acc ^ p;
            end else begin
                acc = acc;
            end
            p = xtime(p);
        end
        return acc;
    endfunction

    // Circulant coefficient for column distance d = (j - k) mod 8
    function automatic logic [3:0] coef(input logic [2:0] d);
        logic [3:0] c;
        case (d)
            3'd0: c = 4'h1;  3'd1: c = 4'h1;  3'd2: c = 4'h4;  3'd3: c = 4'h1;
            3'd4: c = 4'h8;  3'd5: c = 4'h5;  3'd6: c = 4'h2;  3'd7: c = 4'h9;
            default: c = 4'h0;
        endcase
        return c;
    endfunction

    logic [7:0] sub_s [0:7];

    // gamma: S-box substitution of all eight bytes
    always_comb begin
        for (int j = 0; j < 8; j++) begin
            sub_s[j] = sbox(row_in[63-8*j -: 8]);
        end
    end

    // theta: out byte j = XOR over k of sub[k] * c[(j-k) mod 8]
    always_comb begin
        row_out = 64'd0;
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 8; k++) begin
                row_out[63-8*j -: 8] = row_out[63-8*j -: 8] ^ gmul(sub_s[k], coef(3'(j - k)));
            end
        end
    end

endmodule

module whirlpool_round_unit #(
    parameter int PAR = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] state_in,
    input  logic [511:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] state_out
);

    localparam int NCYC = 8 / PAR;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t         fsm_r;
    logic [2:0]   cnt_r;
    logic [511:0] a_r;
    logic [511:0] k_r;

    logic [2:0]   row_idx_s [0:PAR-1];
    logic [63:0]  pi_row_s  [0:PAR-1];
    logic [63:0]  row_res_s [0:PAR-1];

    // pi: byte j of output row r comes from input row (r - j) mod 8, column j
    function automatic logic [63:0] pi_row(input logic [511:0] a, input logic [2:0] r);
        logic [63:0] row;
        logic [2:0]  src;
        row = 64'd0;
        for (int j = 0; j < 8; j++) begin
            src = r - 3'(j);
            row[63-8*j -: 8] = a[511-64*int'(src)-8*j -: 8];
        end
        return row;
    endfunction

    // Rows handled this cycle and their pi-shifted inputs
    always_comb begin
        for (int p = 0; p < PAR; p++) begin
            row_idx_s[p] = 3'(int'(cnt_r) * PAR + p);
            pi_row_s[p]  = pi_row(a_r, row_idx_s[p]);
        end
    end

    for (genvar g = 0; g < PAR; g++) begin : g_row
        process_row u_row (
            .row_in  (pi_row_s[g]),
            .row_out (row_res_s[g])
        );
    end

    // Round FSM: accept, compute NCYC row groups, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r     <= IDLE;
            cnt_r     <= 3'd0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            state_out <= 512'd0;
            a_r       <= 512'd0;
            k_r       <= 512'd0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= state_in;
                        k_r      <= key_in;
                        cnt_r    <= 3'd0;
                        in_ready <= 1'b0;
                        fsm_r    <= RUN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    for (int p = 0; p < PAR; p++) begin
                        state_out[511-64*int'(row_idx_s[p]) -: 64] <=
                            row_res_s[p] ^ k_r[511-64*int'(row_idx_s[p]) -: 64];
                    end
                    cnt_r <= cnt_r + 3'd1;
                    if (cnt_r == 3'(NCYC - 1)) begin
                        out_valid <= 1'b1;
                        fsm_r     <= DONE;
                    end else begin
                        fsm_r     <= RUN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm_r     <= IDLE;
                    end else begin
                        fsm_r     <= DONE;
                    end
                end
                default: begin
                    fsm_r     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
